// File: rtl/mvm_result_buffer.sv
// mvm_result_buffer
//   Downstream stage of the 4x4 matrix-vector multiply-add block. Each accepted
//   result is saturated if the multiplier flagged an overflow. It is then tagged
//   with its element index within the vector and an end-of-vector marker, and
//   queued in a small first-word-fall-through FIFO. The FIFO decouples the
//   multiplier from a slow consumer.
//
//   Optional feature (compile-time macro MVM_RESULT_RELU_EN): after saturation,
//   negative results are replaced by zero. The saturation flag is kept unchanged.
//
// Parameters
//   K        elements per result vector (>= 2); sets the m_last period
//   DEPTH    FIFO entries, power of two, >= 2
//   LOGDEPTH log2(DEPTH)
//
// Ports
//   clk       clock, all logic on posedge
//   reset     synchronous active-low reset
//   s_valid   upstream beat valid (multiplier m_valid)
//   s_ready   buffer can accept a beat (count < DEPTH)
//   data_in   signed upstream result
//   ovf_in    upstream overflow flag, qualified by s_valid
//   m_valid   output beat valid (count != 0)
//   m_ready   downstream accepts beat
//   data_out  saturated (optionally ReLU'd) result at the FIFO head
//   m_ovf     head beat was saturated
//   m_last    head beat is element K-1 of its vector
//   m_index   element index 0..K-1 of the head beat
//   count     FIFO occupancy 0..DEPTH

module mvm_result_buffer #(
   parameter int unsigned K        = 4,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned LOGDEPTH = 3,
   localparam int unsigned LOGK    = $clog2(K)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [15:0]         data_in,
   input  logic                ovf_in,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [15:0]         data_out,
   output logic                m_ovf,
   output logic                m_last,
   output logic [LOGK-1:0]     m_index,
   output logic [LOGDEPTH:0]   count
);

   localparam logic [LOGDEPTH:0] FullCount = DEPTH[LOGDEPTH:0];
   localparam logic [LOGK-1:0]   LastIdx   = LOGK'(K - 1);

   // FIFO storage, one array per entry field
   logic [15:0]         mem_data_q [DEPTH];
   logic                mem_ovf_q  [DEPTH];
   logic [LOGK-1:0]     mem_idx_q  [DEPTH];
   logic                mem_last_q [DEPTH];

   logic [LOGDEPTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [LOGDEPTH:0]   count_q, count_d;
   logic [LOGK-1:0]     in_idx_q, in_idx_d;

   logic                push, pop;
   logic [15:0]         sat_data;
   logic                sat_flag;

   // Handshakes are derived from registered occupancy only. A full FIFO does
   // not accept a beat even when a pop happens in the same cycle.
   assign s_ready = (count_q < FullCount);
   assign m_valid = (count_q != '0);
   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   // An overflow flag means the 16-bit result wrapped. Its sign bit is the
   // opposite of the true sign: a set MSB is a positive wrap, so clamp high.
   always_comb begin
      sat_data = data_in;
      sat_flag = 1'b0;
      if (ovf_in) begin
         sat_flag = 1'b1;
         sat_data = data_in[15] ? 16'h7FFF : 16'h8000;
      end
`ifdef MVM_RESULT_RELU_EN
      if (sat_data[15]) begin
         sat_data = 16'h0000;
      end
`endif
   end

   always_comb begin
      in_idx_d = (in_idx_q == LastIdx) ? '0 : in_idx_q + LOGK'(1);
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         in_idx_q <= '0;
         // Cleared so the head fields read as zero while empty.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_ovf_q[i]  <= 1'b0;
            mem_idx_q[i]  <= '0;
            mem_last_q[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            mem_data_q[wr_ptr_q] <= sat_data;
            mem_ovf_q[wr_ptr_q]  <= sat_flag;
            mem_idx_q[wr_ptr_q]  <= in_idx_q;
            mem_last_q[wr_ptr_q] <= (in_idx_q == LastIdx);
            wr_ptr_q             <= wr_ptr_q + LOGDEPTH'(1);
            in_idx_q             <= in_idx_d;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + LOGDEPTH'(1);
         end
         count_q <= count_d;
      end
   end

   // First-word fall-through: the head entry drives the outputs directly.
   assign data_out = mem_data_q[rd_ptr_q];
   assign m_ovf    = mem_ovf_q[rd_ptr_q];
   assign m_index  = mem_idx_q[rd_ptr_q];
   assign m_last   = mem_last_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: tb/tb_mvm_result_buffer.sv
// tb_mvm_result_buffer
//   Self-checking bench for mvm_result_buffer. A queue-based reference model
//   tracks the expected FIFO contents. The bench derives the saturation, index
//   and last-marker rules itself, using integer arithmetic.

module tb_mvm_result_buffer;

   localparam int K        = 4;
   localparam int DEPTH    = 8;
   localparam int LOGDEPTH = 3;
   localparam int LOGK     = 2;

   typedef struct packed {
      logic [15:0]     d;
      logic            o;
      logic [LOGK-1:0] idx;
      logic            last;
   } beat_t;

   logic                clk;
   logic                reset;
   logic                s_valid;
   logic                s_ready;
   logic [15:0]         data_in;
   logic                ovf_in;
   logic                m_valid;
   logic                m_ready;
   logic [15:0]         data_out;
   logic                m_ovf;
   logic                m_last;
   logic [LOGK-1:0]     m_index;
   logic [LOGDEPTH:0]   count;

   int    vectors;
   int    miscompares;
   beat_t mq[$];
   int    in_idx_m;

   mvm_result_buffer #(
      .K        (K),
      .DEPTH    (DEPTH),
      .LOGDEPTH (LOGDEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .data_in  (data_in),
      .ovf_in   (ovf_in),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .data_out (data_out),
      .m_ovf    (m_ovf),
      .m_last   (m_last),
      .m_index  (m_index),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic beat_t model_beat(logic [15:0] d, logic o);
      beat_t b;
      int    v;
      if (o) v = d[15] ? 32767 : -32768;
      else   v = int'($signed(d));
`ifdef MVM_RESULT_RELU_EN
      if (v < 0) v = 0;
`endif
      b.d    = v[15:0];
      b.o    = o;
      b.idx  = LOGK'(in_idx_m);
      b.last = (in_idx_m == K - 1);
      return b;
   endfunction

   // Advance one clock and update the model from the handshakes it predicts.
   task automatic tick();
      beat_t b;
      beat_t dropped;
      logic  do_push, do_pop;
      do_push = s_valid && (mq.size() < DEPTH);
      do_pop  = (mq.size() != 0) && m_ready;
      b = model_beat(data_in, ovf_in);
      @(posedge clk);
      #1;
      if (!reset) begin
         mq.delete();
         in_idx_m = 0;
      end else begin
         if (do_pop) dropped = mq.pop_front();
         if (do_push) begin
            mq.push_back(b);
            in_idx_m = (in_idx_m + 1) % K;
         end
      end
   endtask

   task automatic drive(logic sv, logic [15:0] d, logic o, logic mr);
      s_valid = sv;
      data_in = d;
      ovf_in  = o;
      m_ready = mr;
   endtask

   task automatic drain();
      int n;
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      n = 0;
      while (mq.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      vectors++;
      if (m_valid !== 1'b0) begin
         $display("FAIL drain_empty: m_valid=%b required 0", m_valid);
         miscompares++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      vectors += 7;
      if (s_ready !== 1'b1) begin $display("FAIL rst_s_ready: %b vs 1", s_ready); miscompares++; end
      if (m_valid !== 1'b0) begin $display("FAIL rst_m_valid: %b vs 0", m_valid); miscompares++; end
      if (count !== 4'd0) begin $display("FAIL rst_count: %0d vs 0", count); miscompares++; end
      if (data_out !== 16'h0) begin $display("FAIL rst_data: %h vs 0000", data_out); miscompares++; end
      if (m_ovf !== 1'b0) begin $display("FAIL rst_ovf: %b vs 0", m_ovf); miscompares++; end
      if (m_last !== 1'b0) begin $display("FAIL rst_last: %b vs 0", m_last); miscompares++; end
      if (m_index !== 2'd0) begin $display("FAIL rst_index: %0d vs 0", m_index); miscompares++; end
   endtask

   task automatic test_basic();
      logic [15:0] din [4];
      logic [15:0] exp [4];
      din[0] = 16'd10; din[1] = 16'hFFFD; din[2] = 16'd7; din[3] = 16'd300;
      exp = din;
`ifdef MVM_RESULT_RELU_EN
      exp[1] = 16'h0000;
`endif
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, din[i], 1'b0, 1'b1);
         tick();
         vectors += 5;
         if (m_valid !== 1'b1) begin $display("FAIL basic_valid[%0d]: %b vs 1", i, m_valid); miscompares++; end
         if (data_out !== exp[i]) begin
            $display("FAIL basic_data[%0d]: %h vs %h", i, data_out, exp[i]); miscompares++;
         end
         if (m_index !== LOGK'(i)) begin $display("FAIL basic_index[%0d]: %0d vs %0d", i, m_index, i); miscompares++; end
         if (m_last !== (i == 3)) begin $display("FAIL basic_last[%0d]: %b vs %b", i, m_last, i == 3); miscompares++; end
         if (count !== 4'd1) begin $display("FAIL basic_count[%0d]: %0d vs 1", i, count); miscompares++; end
      end
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      tick();
      vectors++;
      if (m_valid !== 1'b0) begin $display("FAIL basic_empty: m_valid=%b vs 0", m_valid); miscompares++; end
   endtask

   task automatic test_full();
      logic [15:0] vals [9];
      int          acc;
      int          j;
      for (int i = 0; i < 9; i++) vals[i] = 16'($urandom_range(0, 32767));
      acc = 0;
      for (int c = 0; c < 9; c++) begin
         drive(1'b1, vals[acc], 1'b0, 1'b0);
         if (mq.size() < DEPTH) begin
            tick();
            acc++;
         end else begin
            tick();
         end
      end
      vectors += 3;
      if (count !== 4'd8) begin $display("FAIL full_count: %0d vs 8", count); miscompares++; end
      if (s_ready !== 1'b0) begin $display("FAIL full_s_ready: %b vs 0", s_ready); miscompares++; end
      if (data_out !== vals[0]) begin $display("FAIL full_head: %h vs %h", data_out, vals[0]); miscompares++; end
      // Release: first edge only pops (s_ready was low), second pops and pushes.
      drive(1'b1, vals[8], 1'b0, 1'b1);
      tick();
      vectors += 2;
      if (count !== 4'd7) begin $display("FAIL full_pop_count: %0d vs 7", count); miscompares++; end
      if (s_ready !== 1'b1) begin $display("FAIL full_reopen: %b vs 1", s_ready); miscompares++; end
      tick();
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      vectors++;
      if (count !== 4'd7) begin $display("FAIL full_pushpop_count: %0d vs 7", count); miscompares++; end
      j = 2;
      while (m_valid === 1'b1 && j < 9) begin
         vectors++;
         if (data_out !== vals[j]) begin
            $display("FAIL full_order[%0d]: %h vs %h", j, data_out, vals[j]); miscompares++;
         end
         tick();
         j++;
      end
      vectors += 2;
      if (j !== 9) begin $display("FAIL full_drained: beats=%0d vs 9", j); miscompares++; end
      if (m_valid !== 1'b0) begin $display("FAIL full_empty: %b vs 0", m_valid); miscompares++; end
   endtask

   task automatic test_saturation();
      logic [15:0] exp_neg;
`ifdef MVM_RESULT_RELU_EN
      exp_neg = 16'h0000;
`else
      exp_neg = 16'h8000;
`endif
      drive(1'b1, 16'h8005, 1'b1, 1'b1);
      tick();
      vectors += 2;
      if (data_out !== 16'h7FFF) begin $display("FAIL sat_pos_data: %h vs 7fff", data_out); miscompares++; end
      if (m_ovf !== 1'b1) begin $display("FAIL sat_pos_ovf: %b vs 1", m_ovf); miscompares++; end
      drive(1'b1, 16'h7FF0, 1'b1, 1'b1);
      tick();
      vectors += 2;
      if (data_out !== exp_neg) begin $display("FAIL sat_neg_data: %h vs %h", data_out, exp_neg); miscompares++; end
      if (m_ovf !== 1'b1) begin $display("FAIL sat_neg_ovf: %b vs 1", m_ovf); miscompares++; end
      drive(1'b1, 16'h8005, 1'b0, 1'b1);
      tick();
      vectors += 2;
      if (data_out !== mq[0].d) begin $display("FAIL sat_none_data: %h vs %h", data_out, mq[0].d); miscompares++; end
      if (m_ovf !== 1'b0) begin $display("FAIL sat_none_ovf: %b vs 0", m_ovf); miscompares++; end
      drain();
   endtask

   task automatic test_stream();
      int lasts;
      drive(1'b1, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         data_in = 16'($urandom_range(0, 65535));
         tick();
      end
      vectors++;
      if (count !== 4'd3) begin $display("FAIL stream_fill: %0d vs 3", count); miscompares++; end
      lasts = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 16'($urandom_range(0, 65535)), 1'b0, 1'b1);
         vectors += 4;
         if (m_valid !== 1'b1 || data_out !== mq[0].d) begin
            $display("FAIL stream_data[%0d]: %h vs %h", i, data_out, mq[0].d); miscompares++;
         end
         if (m_last !== mq[0].last) begin
            $display("FAIL stream_last[%0d]: %b vs %b", i, m_last, mq[0].last); miscompares++;
         end
         if (m_index !== mq[0].idx) begin
            $display("FAIL stream_index[%0d]: %0d vs %0d", i, m_index, mq[0].idx); miscompares++;
         end
         if (m_last === 1'b1) lasts++;
         tick();
         if (count !== 4'd3) begin $display("FAIL stream_count[%0d]: %0d vs 3", i, count); miscompares++; end
      end
      vectors++;
      if (lasts !== 10) begin $display("FAIL stream_last_total: %0d vs 10", lasts); miscompares++; end
      drain();
   endtask

   task automatic test_midreset();
      drive(1'b1, 16'd11, 1'b0, 1'b0);
      tick();
      data_in = 16'd12;
      tick();
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      vectors += 4;
      if (m_valid !== 1'b0) begin $display("FAIL mrst_valid: %b vs 0", m_valid); miscompares++; end
      if (count !== 4'd0) begin $display("FAIL mrst_count: %0d vs 0", count); miscompares++; end
      if (s_ready !== 1'b1) begin $display("FAIL mrst_s_ready: %b vs 1", s_ready); miscompares++; end
      if (data_out !== 16'h0) begin $display("FAIL mrst_data: %h vs 0000", data_out); miscompares++; end
      drive(1'b1, 16'd55, 1'b0, 1'b0);
      tick();
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      vectors += 3;
      if (m_index !== 2'd0) begin $display("FAIL mrst_index: %0d vs 0", m_index); miscompares++; end
      if (data_out !== 16'd55) begin $display("FAIL mrst_next_data: %h vs 0037", data_out); miscompares++; end
      if (count !== 4'd1) begin $display("FAIL mrst_next_count: %0d vs 1", count); miscompares++; end
      drain();
   endtask

   task automatic test_random();
      logic [15:0] src_d [40];
      logic        src_o [40];
      int          sent;
      int          popped;
      int          cyc;
      for (int i = 0; i < 40; i++) begin
         src_d[i] = 16'($urandom_range(0, 65535));
         src_o[i] = ($urandom_range(0, 7) == 0);
      end
      sent   = 0;
      popped = 0;
      cyc    = 0;
      while ((sent < 40 || mq.size() != 0) && cyc < 2000) begin
         drive((sent < 40) && ($urandom_range(0, 3) != 0),
               (sent < 40) ? src_d[sent] : 16'h0,
               (sent < 40) ? src_o[sent] : 1'b0,
               ($urandom_range(0, 2) != 0));
         vectors += 3;
         if (s_ready !== (mq.size() < DEPTH)) begin
            $display("FAIL rnd_s_ready[%0d]: %b vs %b", cyc, s_ready, mq.size() < DEPTH); miscompares++;
         end
         if (count !== 4'(mq.size())) begin
            $display("FAIL rnd_count[%0d]: %0d vs %0d", cyc, count, mq.size()); miscompares++;
         end
         if (m_valid !== (mq.size() != 0)) begin
            $display("FAIL rnd_valid[%0d]: %b vs %b", cyc, m_valid, mq.size() != 0); miscompares++;
         end else if (mq.size() != 0) begin
            vectors++;
            if ({data_out, m_ovf, m_index, m_last} !== mq[0]) begin
               $display("FAIL rnd_beat[%0d]: %h/%b/%0d/%b vs %h/%b/%0d/%b", cyc, data_out, m_ovf,
                        m_index, m_last, mq[0].d, mq[0].o, mq[0].idx, mq[0].last);
               miscompares++;
            end
            if (m_ready) popped++;
         end
         if (s_valid && mq.size() < DEPTH) sent++;
         tick();
         cyc++;
      end
      vectors++;
      if (popped !== 40) begin $display("FAIL rnd_total: popped=%0d vs 40", popped); miscompares++; end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      in_idx_m    = 0;
      reset       = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      test_reset();
      test_basic();
      test_full();
      test_saturation();
      test_stream();
      test_midreset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
